// File: rtl/piso_pkg.sv
// ============================================================================
//  piso_pkg : shared state encoding and frame-length helper for piso_tx
//  Optional macro: PISO_PARITY_EN (appends an even-parity bit to every frame)
//  Revision: 1.0
// ============================================================================
`default_nettype none

package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    function automatic int FRAME_LEN(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_frame_cnt.sv
// ============================================================================
//  piso_frame_cnt : data-bit counter with clear/enable, reports the final bit
//  and the bit just before it.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module piso_frame_cnt #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic near,
    output logic tc
);

    localparam int                c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_near  = c_cnt_w'(WIDTH - 2);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign tc   = (r_cnt == c_last);
    assign near = (r_cnt == c_near);

endmodule

`default_nettype wire

// File: rtl/piso_tx.sv
// ============================================================================
//  piso_tx : parallel-in serial-out transmitter, MSB first, ready/load accept.
//  Optional macro: PISO_PARITY_EN (adds trailing even-parity bit)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             busy,
    output logic             last
);

`ifdef PISO_PARITY_EN
    localparam bit c_parity_en = 1'b1;
`else
    localparam bit c_parity_en = 1'b0;
`endif

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_shreg, w_shreg_nxt;
    logic               r_q, w_q_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_last, w_last_nxt;
    logic               r_ready, w_ready_nxt;
    logic               w_cnt_clr, w_cnt_en;
    logic               w_near, w_tc;
`ifdef PISO_PARITY_EN
    logic               r_par, w_par_nxt;
`endif

    piso_frame_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_cnt_clr),
        .en   (w_cnt_en),
        .near (w_near),
        .tc   (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_q     <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
            r_ready <= 1'b1;
`ifdef PISO_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_q     <= w_q_nxt;
            r_busy  <= w_busy_nxt;
            r_last  <= w_last_nxt;
            r_ready <= w_ready_nxt;
`ifdef PISO_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_q_nxt     = 1'b0;
        w_busy_nxt  = 1'b0;
        w_last_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
`ifdef PISO_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            IDLE: begin
                w_ready_nxt = 1'b1;
                if (load && r_ready) begin
                    w_shreg_nxt = din;
                    w_q_nxt     = din[WIDTH-1];
                    w_busy_nxt  = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
                    w_par_nxt   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (!w_tc) begin
                    w_shreg_nxt = r_shreg << 1;
                    w_q_nxt     = r_shreg[WIDTH-2];
                    w_busy_nxt  = 1'b1;
                    w_last_nxt  = w_near & ~c_parity_en;
                    w_cnt_en    = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    w_q_nxt     = r_par;
                    w_busy_nxt  = 1'b1;
                    w_last_nxt  = 1'b1;
                    w_state_nxt = PARITY;
`else
                    w_ready_nxt = 1'b1;
                    w_state_nxt = IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                w_ready_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
`endif
            default: begin
                w_ready_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign q     = r_q;
    assign busy  = r_busy;
    assign last  = r_last;
    assign ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_piso_tx.sv
// ============================================================================
//  tb_piso_tx : self-checking bench for piso_tx (WIDTH=4), table vectors,
//  directed corner sequences and randomized traffic against a frame-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_piso_tx;

    localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = WIDTH + (PAR ? 1 : 0);

    logic             clk = 1'b0;
    logic             rst;
    logic             load = 1'b0;
    logic [WIDTH-1:0] din  = '0;
    logic             q, busy, last, ready;

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .load  (load),
        .ready (ready),
        .q     (q),
        .busy  (busy),
        .last  (last)
    );

    always #5 clk = ~clk;

    // Receiving shift register, fills at bit 0 like the downstream SIPO.
    logic [WIDTH-1:0] sipo = '0;
    always @(posedge clk) sipo <= {sipo[WIDTH-2:0], q};

    int checks   = 0;
    int failures = 0;

    // Frame-level reference: a queue of bits still to be sent after the current one.
    bit m_q, m_busy, m_last, m_ready;
    bit m_rem[$];

    typedef struct {
        bit               ld;
        logic [WIDTH-1:0] d;
        logic [3:0]       exp;   // {q, busy, last, ready}
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem.delete();
        m_q = 1'b0; m_busy = 1'b0; m_last = 1'b0; m_ready = 1'b1;
    endtask

    task automatic model_edge(input bit ld, input logic [WIDTH-1:0] d);
        if (m_ready) begin
            if (ld) begin
                m_rem.delete();
                for (int i = WIDTH - 1; i >= 0; i--) m_rem.push_back(d[i]);
                if (PAR) m_rem.push_back(^d);
                m_q     = m_rem.pop_front();
                m_busy  = 1'b1;
                m_ready = 1'b0;
                m_last  = (m_rem.size() == 0);
            end else begin
                m_q = 1'b0; m_busy = 1'b0; m_last = 1'b0; m_ready = 1'b1;
            end
        end else if (m_rem.size() > 0) begin
            m_q    = m_rem.pop_front();
            m_last = (m_rem.size() == 0);
        end else begin
            m_q = 1'b0; m_busy = 1'b0; m_last = 1'b0; m_ready = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(load, din);
        #1;
    endtask

    task automatic check_model(input string name);
        check(name, {q, busy, last, ready}, {m_q, m_busy, m_last, m_ready});
    endtask

    initial begin
        logic [WIDTH-1:0] bits;
        int               nlast;

`ifdef PISO_PARITY_EN
        tbl.push_back('{1'b1, 4'b1011, 4'b1100});
        tbl.push_back('{1'b0, 4'b0000, 4'b0100});
        tbl.push_back('{1'b0, 4'b0000, 4'b1100});
        tbl.push_back('{1'b0, 4'b0000, 4'b1100});
        tbl.push_back('{1'b0, 4'b0000, 4'b1110});
        tbl.push_back('{1'b0, 4'b0000, 4'b0001});
        tbl.push_back('{1'b1, 4'b1001, 4'b1100});
        tbl.push_back('{1'b0, 4'b0000, 4'b0100});
        tbl.push_back('{1'b0, 4'b0000, 4'b0100});
        tbl.push_back('{1'b0, 4'b0000, 4'b1100});
        tbl.push_back('{1'b0, 4'b0000, 4'b0110});
        tbl.push_back('{1'b0, 4'b0000, 4'b0001});
`else
        tbl.push_back('{1'b1, 4'b1011, 4'b1100});
        tbl.push_back('{1'b0, 4'b0000, 4'b0100});
        tbl.push_back('{1'b0, 4'b0000, 4'b1100});
        tbl.push_back('{1'b0, 4'b0000, 4'b1110});
        tbl.push_back('{1'b0, 4'b0000, 4'b0001});
        tbl.push_back('{1'b0, 4'b0000, 4'b0001});
        tbl.push_back('{1'b1, 4'b1100, 4'b1100});
        tbl.push_back('{1'b1, 4'b0011, 4'b1100});
        tbl.push_back('{1'b1, 4'b0011, 4'b0100});
        tbl.push_back('{1'b0, 4'b0011, 4'b0110});
        tbl.push_back('{1'b0, 4'b0000, 4'b0001});
        tbl.push_back('{1'b0, 4'b0000, 4'b0001});
`endif

        rst = 1'b0;
        #1 rst = 1'b1;
        #2 check("reset_state", {q, busy, last, ready}, 4'b0001);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();

        // Table vectors: inputs applied before an edge, outputs checked after it.
        foreach (tbl[i]) begin
            load = tbl[i].ld;
            din  = tbl[i].d;
            tick();
            check($sformatf("vec%0d", i), {q, busy, last, ready}, tbl[i].exp);
        end
        load = 1'b0;

        // Loopback into the receiving shift register.
        din = 4'b0110; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (WIDTH) tick();
        check("loopback", sipo, 4'b0110);
        repeat (FL) tick();
        check_model("loopback_idle");

        // Asynchronous reset in the middle of a frame.
        din = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1 check("rst_async", {q, busy, last, ready}, 4'b0001);
        model_reset();
        #2 rst = 1'b0;
        din = 4'b1001; load = 1'b1;
        tick();
        load = 1'b0;
        bits = '0;
        for (int k = 0; k < FL; k++) begin
            check_model($sformatf("after_rst_bit%0d", k));
            if (k < WIDTH) bits[WIDTH-1-k] = q;
            tick();
        end
        check("after_rst_word", bits, 4'b1001);
        check_model("after_rst_idle");

        // Load held high: back-to-back frames with one idle cycle between.
        nlast = 0;
        din = 4'b1010; load = 1'b1;
        for (int c = 0; c < 3 * (FL + 1); c++) begin
            tick();
            check_model($sformatf("cont%0d", c));
            if (last === 1'b1) nlast++;
        end
        check("cont_last_count", nlast, 3);
        load = 1'b0;
        repeat (FL + 1) tick();

        // Randomized traffic against the reference.
        for (int c = 0; c < 400; c++) begin
            load = ($urandom_range(0, 3) == 0);
            din  = WIDTH'($urandom);
            tick();
            check_model($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out shift transmitter: the sending end of our serial bit stream, feeding the SIPO receiver's `d` input one bit per clock. It accepts a WIDTH-bit word through a ready/load handshake and shifts it out MSB-first, so a SIPO that shifts in at q[0] holds the original word after WIDTH clocks. It provides busy and last-bit flags so the receiving side or a controller can frame words.

## Interface
- WIDTH, 4, data word width in bits; legal range WIDTH >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- din  input  WIDTH  parallel word; sampled only on the accept edge.
- load  input  1  request to transmit din.
- ready  output  1  block can accept a word; high only in IDLE.
- q  output  WIDTH=1  serial data out, registered; connects to SIPO `d`.
- busy  output  1  high while q carries a frame bit.
- last  output  1  high while q carries the final bit of the frame.

## Operation
- States: IDLE, SHIFT, PARITY. PARITY exists only with PISO_PARITY_EN.
- IDLE:
  - ready=1, busy=0, last=0, q=0.
  - Accept = load & ready at a clk edge. On accept:
    - shift register <= din
    - q <= din[WIDTH-1]
    - bit counter <= 0
    - state -> SHIFT
- SHIFT: each edge shifts left and presents the next lower bit on q, and increments the counter.
  - When the counter reaches WIDTH-1, q holds din[0] and last=1. Parity build asserts last in PARITY instead.
  - Edge after the din[0] cycle:
    - no parity: go to IDLE.
    - parity: go to PARITY with q <= ^din.
- PARITY: q = even-parity bit (XOR of the accepted word). Total ones across the frame is even. last=1. Next edge: go to IDLE.
- A load while ready=0 is ignored. The word in flight is unaffected, and later changes to din have no effect on it.
- Load held high continuously: the next word is accepted on the first IDLE edge. Frames are separated by exactly one idle cycle with q=0.
- Counter width is $clog2(WIDTH). The counter never wraps within a frame and is cleared on every accept.
- Reset, including mid-frame: the frame is aborted immediately, asynchronously. State=IDLE, q=0, busy=0, last=0, ready=1, shift register=0, counter=0. Operation resumes on the first edge after rst deasserts.

## Timing
- Accept edge E0. q=din[WIDTH-1-k] during the cycle following edge Ek, for k = 0..WIDTH-1.
- busy=1 for WIDTH cycles, or WIDTH+1 cycles with parity, starting the cycle after E0.
- last=1 for exactly one cycle, coincident with the final bit.
- ready falls at E0 and rises at the edge that ends the final bit. Minimum accept-to-accept spacing is WIDTH+1 cycles, or WIDTH+2 with parity.
- All outputs are registered. There is no combinational path from load or din to any output.

## Configuration
- PISO_PARITY_EN:
  - Defined: adds the PARITY state. The frame is WIDTH+1 bits ending in an even-parity bit, and last moves to the parity cycle.
  - Undefined: the frame is exactly WIDTH data bits and the PARITY state and XOR logic are absent.

## Structure
- Package piso_pkg holds:
  - the state typedef (IDLE, SHIFT, PARITY)
  - the frame length function FRAME_LEN(WIDTH), returning WIDTH or WIDTH+1 depending on PISO_PARITY_EN.
- One sub-module is natural: piso_frame_cnt. It is the bit counter with clear/enable inputs and a terminal-count output, and drives last and the SHIFT exit.

## Test plan (WIDTH=4)
- Basic transmit: din=4'b1011, load pulse at E0.
  - q=1,0,1,1 on the following 4 cycles; busy high for those 4 cycles; last on the 4th.
  - ready back high after that; q=0 afterwards.
- Loopback: piso_tx q drives a 4-bit SIPO `d` on the same clk, transmit 4'b0110 → SIPO q=4'b0110 after the 4th shift.
- Load while busy: accept 4'b1100, then pulse load with din=4'b0011 during the 2nd bit → stream stays 1,1,0,0 and the second word is not sent.
- Reset mid-frame: accept 4'b1111, assert rst during the 2nd bit.
  - q, busy, last drop to 0 and ready rises without waiting for a clock.
  - After release, transmitting 4'b1001 gives 1,0,0,1.
- Continuous load: load held high with din=4'b1010 → repeated frames 1,0,1,0 separated by one q=0 idle cycle, with last once per frame.
- Parity (PISO_PARITY_EN defined): 4'b1011 → q=1,0,1,1,1 and 4'b1001 → q=1,0,0,1,0. busy is high for 5 cycles and last is on the 5th.
